// File: rtl/lstm_pkg.sv
// lstm_pkg: shared LSTM state encoding, datapath width and clog2 helper
package lstm_pkg;
   localparam int LSTM_WIDTH = 32;
   typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/sipo_stream_ctrl.sv
// sipo_stream_ctrl: FILL/HOLD sequencing, word count and frame length
module sipo_stream_ctrl
   import lstm_pkg::*;
#(
   parameter int NUM = 68,
   parameter int CW  = clog2(NUM + 1),
   parameter int IW  = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cfg_len,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          out_ready,
   output logic          in_ready,
   output logic          out_valid,
   output logic          we,
   output logic [IW-1:0] widx,
   output logic          clr,
   output logic          ld,
   output logic [CW-1:0] ld_count
);
   state_t        state;
   logic [CW-1:0] count, len_q, san, eff, nxt;
   logic          fill, acc;
   assign fill      = state == ST_FILL;
   assign acc       = fill && in_valid;
   assign san       = (cfg_len == '0 || cfg_len > CW'(NUM)) ? CW'(NUM) : cfg_len;
   // the first word of a frame must see the freshly sanitised length
   assign eff       = (count == '0) ? san : len_q;
   assign nxt       = count + 1'b1;
   assign in_ready  = fill;
   assign out_valid = !fill;
   assign we        = acc;
   assign widx      = count[IW-1:0];
   assign clr       = !fill && out_ready;
   assign ld        = fill && ((acc && nxt == eff) || (flush && (count != '0 || acc)));
   assign ld_count  = acc ? nxt : count;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_FILL;
         count <= '0;
         len_q <= CW'(NUM);
      end else if (fill) begin
         if (acc) count <= nxt;
         if (acc && count == '0) len_q <= san;
         if (ld) state <= ST_HOLD;
      end else if (out_ready) begin
         state <= ST_FILL;
         count <= '0;
      end
   end
endmodule

// File: rtl/sipo_stream.sv
// sipo_stream: valid/ready serial-to-parallel frame assembler with
// runtime length, zero-filled early flush and a word-count sideband
module sipo_stream
   import lstm_pkg::*;
#(
   parameter int WIDTH = LSTM_WIDTH,
   parameter int NUM   = 68,
   parameter int CW    = clog2(NUM + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CW-1:0]        cfg_len,
   input  logic                 flush,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NUM*WIDTH-1:0] o,
   output logic [CW-1:0]        out_count,
   output logic                 out_valid,
   input  logic                 out_ready
);
   localparam int IW = (NUM > 1) ? clog2(NUM) : 1;
   logic [NUM-1:0][WIDTH-1:0] slots;
   logic                      we, clr, ld;
   logic [IW-1:0]             widx;
   logic [CW-1:0]             ld_count;
   sipo_stream_ctrl #(.NUM(NUM), .CW(CW), .IW(IW)) u_ctrl (
      .clk(clk), .rst(rst), .cfg_len(cfg_len), .flush(flush),
      .in_valid(in_valid), .out_ready(out_ready), .in_ready(in_ready),
      .out_valid(out_valid), .we(we), .widx(widx), .clr(clr), .ld(ld),
      .ld_count(ld_count)
   );
   assign o = slots;
   // slots are cleared on delivery, so a short frame is already zero-filled
   always_ff @(posedge clk) begin
      if (!rst) begin
         slots     <= '0;
         out_count <= '0;
      end else begin
         if (clr) slots <= '0;
         else if (we) slots[widx] <= in_data;
         if (clr) out_count <= '0;
         else if (ld) out_count <= ld_count;
      end
   end
endmodule

// File: tb/tb_sipo_stream.sv
// tb_sipo_stream: directed NUM=4 checks plus a randomised NUM=68 scoreboard run
module tb_sipo_stream;
   typedef struct {logic [31:0] o; logic [2:0] cnt;} sf_t;
   typedef struct {logic [67:0][31:0] d; logic [6:0] cnt;} bf_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int n_chk = 0, n_pass = 0, b_del = 0;
   sf_t sq[$];
   bf_t bq[$];
   sf_t se;
   bf_t be;
   logic        s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [2:0]  s_cfg_len, s_out_count;
   logic [7:0]  s_in_data;
   logic [31:0] s_o;
   logic         b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [6:0]   b_cfg_len, b_out_count;
   logic [31:0]  b_in_data;
   logic [2175:0] b_o;
   sipo_stream #(.WIDTH(8), .NUM(4)) u_s (
      .clk(clk), .rst(s_rst), .cfg_len(s_cfg_len), .flush(s_flush),
      .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .o(s_o), .out_count(s_out_count), .out_valid(s_out_valid), .out_ready(s_out_ready)
   );
   sipo_stream #(.WIDTH(32), .NUM(68)) u_b (
      .clk(clk), .rst(b_rst), .cfg_len(b_cfg_len), .flush(b_flush),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .o(b_o), .out_count(b_out_count), .out_valid(b_out_valid), .out_ready(b_out_ready)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic s_send(input logic [7:0] d);
      s_in_valid = 1'b1;
      s_in_data  = d;
      tick();
      s_in_valid = 1'b0;
   endtask
   task automatic s_take();
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
   endtask
   task automatic s_push(input logic [31:0] o, input logic [2:0] cnt);
      sf_t e;
      e.o   = o;
      e.cnt = cnt;
      sq.push_back(e);
   endtask
   always @(negedge clk) begin
      if (s_rst && s_out_valid && s_out_ready) begin
         if (sq.size() == 0) chk("s_extra_frame", 1, 0);
         else begin
            se = sq.pop_front();
            chk("s_frame_o", s_o, se.o);
            chk("s_frame_cnt", s_out_count, se.cnt);
         end
      end
   end
   always @(negedge clk) begin
      if (b_rst && b_out_valid && b_out_ready) begin
         b_del++;
         if (bq.size() == 0) chk("b_extra_frame", 1, 0);
         else begin
            be = bq.pop_front();
            chk("b_frame_cnt", b_out_count, be.cnt);
            for (int k = 0; k < 68; k++) chk("b_slot", b_o[k*32 +: 32], be.d[k]);
         end
      end
   end
   initial begin
      #3000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end
   initial begin
      int   c, eff, stalls, g;
      logic rdy;
      bf_t  e;
      stalls = 0;
      s_rst = 0; s_cfg_len = 3'd4; s_flush = 0; s_in_data = '0; s_in_valid = 0; s_out_ready = 0;
      b_rst = 0; b_cfg_len = '0; b_flush = 0; b_in_data = '0; b_in_valid = 0; b_out_ready = 0;
      tick(); tick();
      chk("rst_o", s_o, 0);
      chk("rst_cnt", s_out_count, 0);
      chk("rst_valid", s_out_valid, 0);
      chk("rst_ready", s_in_ready, 1);
      s_rst = 1;
      // full frame held under back-pressure
      s_push(32'h44332211, 3'd4);
      s_send(8'h11); s_send(8'h22); s_send(8'h33);
      chk("full_not_yet", s_out_valid, 0);
      s_send(8'h44);
      chk("full_valid", s_out_valid, 1);
      chk("full_o", s_o, 32'h44332211);
      chk("full_cnt", s_out_count, 4);
      chk("full_in_ready", s_in_ready, 0);
      s_take();
      chk("clr_o", s_o, 0);
      chk("clr_in_ready", s_in_ready, 1);
      chk("clr_valid", s_out_valid, 0);
      // short length, zero length and mid-frame cfg change
      s_cfg_len = 3'd2;
      s_push(32'h0000A2A1, 3'd2);
      s_send(8'hA1); s_send(8'hA2);
      chk("len2_valid", s_out_valid, 1);
      s_take();
      s_cfg_len = 3'd0;
      s_push(32'h0D0C0B0A, 3'd4);
      s_send(8'h0A);
      s_cfg_len = 3'd2;
      s_send(8'h0B);
      chk("midcfg_no_close", s_out_valid, 0);
      s_send(8'h0C); s_send(8'h0D);
      chk("len0_valid", s_out_valid, 1);
      s_take();
      s_cfg_len = 3'd7;
      s_push(32'h04030201, 3'd4);
      s_send(8'h01); s_send(8'h02); s_send(8'h03);
      chk("len7_not_yet", s_out_valid, 0);
      s_send(8'h04);
      s_take();
      s_cfg_len = 3'd1;
      s_push(32'h000000EE, 3'd1);
      s_send(8'hEE);
      chk("len1_valid", s_out_valid, 1);
      s_take();
      // flush variants
      s_cfg_len = 3'd4;
      s_push(32'h00000605, 3'd2);
      s_send(8'h05); s_send(8'h06);
      s_flush = 1; tick(); s_flush = 0;
      chk("flush_valid", s_out_valid, 1);
      chk("flush_o", s_o, 32'h00000605);
      chk("flush_cnt", s_out_count, 2);
      s_take();
      s_flush = 1; tick(); tick(); s_flush = 0;
      chk("flush_empty_valid", s_out_valid, 0);
      chk("flush_empty_ready", s_in_ready, 1);
      s_push(32'h00070605, 3'd3);
      s_send(8'h05); s_send(8'h06);
      s_flush = 1; s_send(8'h07); s_flush = 0;
      chk("flush_acc_cnt", s_out_count, 3);
      s_take();
      // back-pressure while a word waits
      s_cfg_len = 3'd2;
      s_push(32'h00002221, 3'd2);
      s_send(8'h21); s_send(8'h22);
      s_in_valid = 1; s_in_data = 8'h99;
      repeat (5) tick();
      chk("bp_in_ready", s_in_ready, 0);
      chk("bp_o", s_o, 32'h00002221);
      chk("bp_valid", s_out_valid, 1);
      s_take();
      tick();
      s_in_valid = 0;
      chk("bp_slot0", s_o, 32'h00000099);
      s_push(32'h00009899, 3'd2);
      s_send(8'h98);
      chk("bp_next_valid", s_out_valid, 1);
      s_take();
      // reset mid-frame and in HOLD
      s_cfg_len = 3'd4;
      s_send(8'h01); s_send(8'h02); s_send(8'h03);
      s_rst = 0; tick(); s_rst = 1;
      chk("rstmid_o", s_o, 0);
      chk("rstmid_valid", s_out_valid, 0);
      tick();
      chk("rstmid_valid2", s_out_valid, 0);
      chk("rstmid_cnt", s_out_count, 0);
      s_cfg_len = 3'd2;
      s_send(8'h31); s_send(8'h32);
      chk("rsthold_pre", s_out_valid, 1);
      s_rst = 0; tick(); s_rst = 1;
      chk("rsthold_valid", s_out_valid, 0);
      chk("rsthold_o", s_o, 0);
      chk("s_sb_empty", sq.size(), 0);
      // NUM=68 random frames, gaps in the first half, in_valid tied high after
      tick(); b_rst = 1; b_out_ready = 1;
      for (int f = 0; f < 100; f++) begin
         c   = $urandom_range(0, 80);
         eff = (c == 0 || c > 68) ? 68 : c;
         e.d = '0;
         e.cnt = 7'(eff);
         for (int k = 0; k < eff; k++) e.d[k] = $urandom;
         bq.push_back(e);
         b_cfg_len = 7'(c);
         for (int k = 0; k < eff; k++) begin
            if (f < 50) repeat ($urandom_range(0, 2)) tick();
            b_in_valid = 1;
            b_in_data  = e.d[k];
            g = 0;
            do begin
               rdy = b_in_ready;
               tick();
               if (!rdy) begin
                  g++;
                  if (f >= 50) stalls++;
               end
            end while (!rdy && g < 10);
            if (!rdy) chk("b_accept_timeout", 0, 1);
            b_in_valid = 0;
         end
      end
      repeat (3) tick();
      chk("b_sb_empty", bq.size(), 0);
      chk("b_delivered", b_del, 100);
      chk("b_bubbles", stalls, 50);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
